// File: rtl/wb_pkg.sv
// Shared widths and the buffered-result record for the writeback arbiter.
package wb_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular result buffer: up to two pushes and one pop per cycle.
// Entries are exposed oldest-first so callers can resolve age without knowing the pointers.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                push_n,
    input  wb_entry_t                 push0,
    input  wb_entry_t                 push1,
    input  logic                      pop,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          ent_valid,
    output wb_entry_t [DEPTH-1:0]     entries
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_nxt;

    assign wr_nxt = wr_ptr + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push_n) - CW'(pop);
        end
    end

    // Storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wr_ptr] <= push0;
        if (push_n == 2'd2) mem[wr_nxt] <= push1;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k]   = mem[rd_ptr + PW'(k)];
            ent_valid[k] = (CW'(k) < count);
        end
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// Dual-lane writeback buffer draining one result per cycle into the register-file write port.
// Define WB_FORWARD_EN to add the q_data0/q_data1 forwarding ports.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            l0_valid,
    input  logic [AW-1:0]   l0_rd,
    input  logic [XLEN-1:0] l0_data,
    input  logic            l1_valid,
    input  logic [AW-1:0]   l1_rd,
    input  logic [XLEN-1:0] l1_data,
    output logic            in_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd,
    input  logic [AW-1:0]   q_addr0,
    input  logic [AW-1:0]   q_addr1,
    output logic            q_busy0,
    output logic            q_busy1,
    output logic            empty
`ifdef WB_FORWARD_EN
    ,
    output logic [XLEN-1:0] q_data0,
    output logic [XLEN-1:0] q_data1
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  acc0, acc1, pop;
    logic [1:0]            push_n;
    wb_entry_t             e0, e1, push0, head;
    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      ent_valid;
    wb_entry_t [DEPTH-1:0] entries;

    function automatic logic pending(input logic [AW-1:0] a,
                                     input wb_entry_t [DEPTH-1:0] ents,
                                     input logic [DEPTH-1:0] vld,
                                     input logic we,
                                     input logic [AW-1:0] wa);
        logic hit;
        hit = we & (wa == a);
        for (int k = 0; k < DEPTH; k++) hit = hit | (vld[k] & (ents[k].rd == a));
        return (a != '0) & hit;
    endfunction

    // Acceptance is decided on the registered count only; x0 results are taken but never stored.
    assign in_ready = ((CW'(DEPTH) - count) >= CW'(2));
    assign acc0     = l0_valid & in_ready & (l0_rd != '0);
    assign acc1     = l1_valid & in_ready & (l1_rd != '0);
    assign e0       = '{rd: l0_rd, data: l0_data};
    assign e1       = '{rd: l1_rd, data: l1_data};
    assign push_n   = {1'b0, acc0} + {1'b0, acc1};
    assign push0    = acc0 ? e0 : e1;
    assign pop      = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_n    (push_n),
        .push0     (push0),
        .push1     (e1),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .ent_valid (ent_valid),
        .entries   (entries)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= pop;
            if (pop) begin
                rf_wa <= head.rd;
                rf_wd <= head.data;
            end
        end
    end

    assign q_busy0 = pending(q_addr0, entries, ent_valid, rf_we, rf_wa);
    assign q_busy1 = pending(q_addr1, entries, ent_valid, rf_we, rf_wa);
    assign empty   = (count == '0) & ~rf_we;

`ifdef WB_FORWARD_EN
    function automatic logic [XLEN-1:0] newest(input logic [AW-1:0] a,
                                               input wb_entry_t [DEPTH-1:0] ents,
                                               input logic [DEPTH-1:0] vld,
                                               input logic we,
                                               input logic [AW-1:0] wa,
                                               input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] v;
        v = '0;
        if (we && (wa == a) && (a != '0)) v = wd;
        // Entries run oldest to newest, so the last hit is the youngest value.
        for (int k = 0; k < DEPTH; k++)
            if (vld[k] && (ents[k].rd == a)) v = ents[k].data;
        return v;
    endfunction

    assign q_data0 = newest(q_addr0, entries, ent_valid, rf_we, rf_wa, rf_wd);
    assign q_data1 = newest(q_addr1, entries, ent_valid, rf_we, rf_wa, rf_wd);
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboarded bench for wb_write_arbiter: expected writes queued on acceptance, checked as rf_we fires.
module tb_wb_write_arbiter;
    import wb_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            l0_valid, l1_valid;
    logic [AW-1:0]   l0_rd, l1_rd;
    logic [XLEN-1:0] l0_data, l1_data;
    logic            in_ready, rf_we, q_busy0, q_busy1, empty;
    logic [AW-1:0]   rf_wa, q_addr0, q_addr1;
    logic [XLEN-1:0] rf_wd;
`ifdef WB_FORWARD_EN
    logic [XLEN-1:0] q_data0, q_data1;
`endif

    int checks = 0;
    int errors = 0;
    wb_entry_t       exp_q[$];
    logic [XLEN-1:0] rf_model [32];

    always #5 clk = ~clk;

    wb_write_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .l0_valid(l0_valid), .l0_rd(l0_rd), .l0_data(l0_data),
        .l1_valid(l1_valid), .l1_rd(l1_rd), .l1_data(l1_data),
        .in_ready(in_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .q_addr0(q_addr0), .q_addr1(q_addr1),
        .q_busy0(q_busy0), .q_busy1(q_busy1), .empty(empty)
`ifdef WB_FORWARD_EN
        , .q_data0(q_data0), .q_data1(q_data1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v0, input logic [AW-1:0] rd0, input logic [XLEN-1:0] d0,
                        input logic v1, input logic [AW-1:0] rd1, input logic [XLEN-1:0] d1);
        int n;
        l0_valid = v0; l0_rd = rd0; l0_data = d0;
        l1_valid = v1; l1_rd = rd1; l1_data = d1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1'b1);
        else begin
            if (v0 && rd0 != '0) exp_q.push_back('{rd: rd0, data: d0});
            if (v1 && rd1 != '0) exp_q.push_back('{rd: rd1, data: d1});
        end
        tick();
        l0_valid = 1'b0;
        l1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!empty && n < 50) begin
            tick();
            n++;
        end
        if (!empty) check("drain_timeout", empty, 1'b1);
    endtask

    // Scoreboard: every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                check("extra_write", rf_we, 1'b0);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                check("wr_addr", rf_wa, e.rd);
                check("wr_data", rf_wd, e.data);
            end
            rf_model[rf_wa] = rf_wd;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XLEN-1:0] fwd_exp [4];
        logic            busy_exp [4];
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        rst_n = 1'b0;
        l0_valid = 1'b0; l0_rd = '0; l0_data = '0;
        l1_valid = 1'b0; l1_rd = '0; l1_data = '0;
        q_addr0 = 5'd5; q_addr1 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", rf_we, 1'b0);
        check("rst_wa", rf_wa, '0);
        check("rst_wd", rf_wd, '0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_empty", empty, 1'b1);
        check("rst_busy0", q_busy0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single write: cycle N accept, N+2 write, N+3 idle.
        l0_valid = 1'b1; l0_rd = 5'd5; l0_data = 32'hDEADBEEF;
        check("single_ready", in_ready, 1'b1);
        exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        tick();
        l0_valid = 1'b0;
        check("lat_n1_we", rf_we, 1'b0);
        check("lat_n1_busy", q_busy0, 1'b1);
        tick();
        check("lat_n2_we", rf_we, 1'b1);
        check("lat_n2_wa", rf_wa, 5'd5);
        check("lat_n2_wd", rf_wd, 32'hDEADBEEF);
        tick();
        check("lat_n3_we", rf_we, 1'b0);
        check("lat_n3_empty", empty, 1'b1);

        // Same destination on both lanes: younger value must land last.
        send(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        wait_idle();
        check("same_rd_final", rf_model[7], 32'h22);

        // x0 on lane0 is dropped; lane1 still written.
        q_addr0 = 5'd3; q_addr1 = 5'd0;
        send(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd3, 32'h1);
        check("x0_busy3", q_busy0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("x0_busy_addr0", q_busy1, 1'b0);
            tick();
        end
        wait_idle();
        check("x0_reg0", rf_model[0], '0);

        // Backpressure: third dual push must stall while only one slot is free.
        send(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
        send(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104);
        check("bp_ready_low", in_ready, 1'b0);
        send(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106);
        wait_idle();

        // Random dual traffic, including occasional x0 and single-lane cycles.
        for (int i = 0; i < 8; i++)
            send(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
        wait_idle();

        // Hazard tracking on rd=9 across buffer and output stage.
        q_addr0 = 5'd9;
        busy_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
        fwd_exp  = '{32'hB2, 32'hB2, 32'hB2, 32'h0};
        send(1'b1, 5'd9, 32'hA1, 1'b1, 5'd9, 32'hB2);
        for (int i = 0; i < 4; i++) begin
            check("haz_busy", q_busy0, busy_exp[i]);
`ifdef WB_FORWARD_EN
            check("haz_fwd", q_data0, fwd_exp[i]);
`endif
            tick();
        end
        wait_idle();

        // Async reset with entries pending discards them.
        q_addr0 = 5'd12;
        send(1'b1, 5'd10, 32'hC0, 1'b1, 5'd11, 32'hC1);
        send(1'b1, 5'd12, 32'hC2, 1'b1, 5'd13, 32'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_we", rf_we, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_empty", empty, 1'b1);
        check("arst_busy", q_busy0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_ready", in_ready, 1'b1);
        check("post_rst_empty", empty, 1'b1);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
